// File: rtl/text_render_if.sv
// Video text path bus: frame/line strobes, memory read ports, cursor and pixel.
interface text_render_if;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PIX_W  = 12;

    logic              newframe;
    logic              newline;
    logic              advance;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_data;
    logic [ADDR_W-1:0] font_addr;
    logic [DATA_W-1:0] font_data;
    logic [ADDR_W-1:0] cursor_addr;
    logic              cursor_en;
    logic [PIX_W-1:0]  pixel;

    // Timing generator and memories side
    modport master (
        output newframe, newline, advance, vram_data, font_data, cursor_addr, cursor_en,
        input  vram_addr, font_addr, pixel
    );

    // Character generator side
    modport slave (
        input  newframe, newline, advance, vram_data, font_data, cursor_addr, cursor_en,
        output vram_addr, font_addr, pixel
    );
endinterface

// File: rtl/text_render.sv
// Text-mode character generator: walks a 64x30 cell grid in videoram, expands
// each cell through an 8x16 font ROM and emits one RGB444 pixel per advance.
module text_render #(
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000,
    parameter int unsigned COLS     = 64,
    parameter int unsigned ROWS     = 30
) (
    input  logic          clk,
    input  logic          reset,
    text_render_if.slave  bus
);
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned SCAN_W  = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BLINK_W = 5;
    localparam int unsigned ADDR_W  = 11;

    localparam logic [COL_W-1:0] COLS_L = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH_CHAR,
        S_FONT,
        S_LOAD
    } state_t;

    state_t              r_state,       w_state_nxt;
    logic [ROW_W-1:0]    r_row,         w_row_nxt;
    logic [SCAN_W-1:0]   r_scan,        w_scan_nxt;
    logic [COL_W-1:0]    r_col,         w_col_nxt;
    logic                r_first_line,  w_first_nxt;
    logic [BLINK_W-1:0]  r_blink,       w_blink_nxt;
    logic [7:0]          r_shift,       w_shift_nxt;
    logic [CNT_W-1:0]    r_cnt,         w_cnt_nxt;
    logic [7:0]          r_buf,         w_buf_nxt;
    logic                r_buf_valid,   w_buf_valid_nxt;
    logic                r_fetch_req,   w_req_nxt;
    logic                r_inv,         w_inv_nxt;
    logic [ADDR_W-1:0]   r_vram_addr,   w_vram_addr_nxt;
    logic [ADDR_W-1:0]   r_font_addr,   w_font_addr_nxt;
    logic [11:0]         r_pixel,       w_pixel_nxt;

    logic                w_can_fetch;
    logic                w_cursor_hit;
    logic [7:0]          w_glyph;
    logic                w_load;
    logic                w_first;
    logic [ROW_W-1:0]    w_row_base;
    logic [SCAN_W-1:0]   w_scan_base;
    logic [7:0]          w_shift_adv;
    logic [CNT_W-1:0]    w_cnt_adv;

    assign bus.vram_addr = r_vram_addr;
    assign bus.pixel     = r_pixel;
    // Font address follows vram_data directly in FONT so the glyph row is back in LOAD
    assign bus.font_addr = (r_state == S_FONT) ? {bus.vram_data[6:0], r_scan} : r_font_addr;

    // Cursor overlay on the bottom two scanlines of the cursor cell while blink is high
    assign w_cursor_hit = bus.cursor_en && ({r_row, r_col[5:0]} == bus.cursor_addr)
                          && r_blink[4] && (r_scan >= 4'd14);
    assign w_glyph      = bus.font_data ^ {8{r_inv}} ^ {8{w_cursor_hit}};
    assign w_can_fetch  = (r_col != COLS_L) && (r_row < ROWS_L);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_scan       <= '0;
            r_col        <= '0;
            r_first_line <= 1'b1;
            r_blink      <= '0;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_buf_valid  <= 1'b0;
            r_fetch_req  <= 1'b0;
            r_inv        <= 1'b0;
            r_vram_addr  <= '0;
            r_font_addr  <= '0;
            r_pixel      <= BG_COLOR;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_scan       <= w_scan_nxt;
            r_col        <= w_col_nxt;
            r_first_line <= w_first_nxt;
            r_blink      <= w_blink_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_buf        <= w_buf_nxt;
            r_buf_valid  <= w_buf_valid_nxt;
            r_fetch_req  <= w_req_nxt;
            r_inv        <= w_inv_nxt;
            r_vram_addr  <= w_vram_addr_nxt;
            r_font_addr  <= w_font_addr_nxt;
            r_pixel      <= w_pixel_nxt;
        end
    end

    // Next-state: frame/line bookkeeping, fetch FSM, shifter and pixel decode
    always_comb begin
        w_state_nxt     = r_state;
        w_col_nxt       = r_col;
        w_blink_nxt     = r_blink;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_buf_nxt       = r_buf;
        w_buf_valid_nxt = r_buf_valid;
        w_req_nxt       = r_fetch_req;
        w_inv_nxt       = r_inv;
        w_vram_addr_nxt = r_vram_addr;
        w_font_addr_nxt = r_font_addr;
        w_load          = 1'b0;
        w_row_base      = r_row;
        w_scan_base     = r_scan;
        w_first         = r_first_line;
        w_shift_adv     = r_shift;
        w_cnt_adv       = r_cnt;

        // Frame start is applied before any same-cycle newline
        if (bus.newframe) begin
            w_row_base  = '0;
            w_scan_base = '0;
            w_first     = 1'b1;
            w_blink_nxt = r_blink + 1'b1;
        end
        w_row_nxt   = w_row_base;
        w_scan_nxt  = w_scan_base;
        w_first_nxt = w_first;

        // Cell fetch: videoram read, font read, glyph load
        case (r_state)
            S_IDLE: begin
                if (r_fetch_req && w_can_fetch) begin
                    w_state_nxt     = S_FETCH_CHAR;
                    w_vram_addr_nxt = {r_row, r_col[5:0]};
                    w_req_nxt       = 1'b0;
                end
            end
            S_FETCH_CHAR: begin
                w_state_nxt = S_FONT;
            end
            S_FONT: begin
                w_inv_nxt       = bus.vram_data[7];
                w_font_addr_nxt = {bus.vram_data[6:0], r_scan};
                w_state_nxt     = S_LOAD;
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_col_nxt   = r_col + 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Advance consumes one pixel; an advance on an empty shifter is ignored
        if (bus.advance && (r_cnt != '0)) begin
            w_shift_adv = {r_shift[6:0], 1'b0};
            w_cnt_adv   = r_cnt - 1'b1;
        end
        w_shift_nxt = w_shift_adv;
        w_cnt_nxt   = w_cnt_adv;

        // Refill an empty shifter from the buffer, or straight from LOAD when the buffer is empty
        if (w_cnt_adv == '0 && r_buf_valid) begin
            w_shift_nxt     = r_buf;
            w_cnt_nxt       = 4'd8;
            w_buf_valid_nxt = 1'b0;
            w_req_nxt       = 1'b1;
            if (w_load) begin
                w_buf_nxt       = w_glyph;
                w_buf_valid_nxt = 1'b1;
            end
        end else if (w_cnt_adv == '0 && w_load) begin
            w_shift_nxt = w_glyph;
            w_cnt_nxt   = 4'd8;
            w_req_nxt   = 1'b1;
        end else if (w_load) begin
            w_buf_nxt       = w_glyph;
            w_buf_valid_nxt = 1'b1;
        end

        // Newline restarts the line and wins over a same-cycle advance or fetch
        if (bus.newline) begin
            if (!w_first) begin
                w_scan_nxt = w_scan_base + 1'b1;
                if (w_scan_base == 4'd15 && w_row_base < ROWS_L) begin
                    w_row_nxt = w_row_base + 1'b1;
                end
            end
            w_first_nxt     = 1'b0;
            w_col_nxt       = '0;
            w_buf_valid_nxt = 1'b0;
            w_cnt_nxt       = '0;
            w_req_nxt       = 1'b0;
            if (w_row_nxt < ROWS_L) begin
                w_state_nxt     = S_FETCH_CHAR;
                w_vram_addr_nxt = {w_row_nxt, 6'd0};
            end else begin
                w_state_nxt = S_IDLE;
            end
        end

        // Pixel reflects the next shifter head so there is no advance-to-pixel lag
        if ((w_cnt_nxt != '0) && w_shift_nxt[7] && (w_row_nxt < ROWS_L) && (w_col_nxt <= COLS_L)) begin
            w_pixel_nxt = FG_COLOR;
        end else begin
            w_pixel_nxt = BG_COLOR;
        end
    end
endmodule

// File: tb/tb_text_render.sv
// Bench for text_render: videoram/font models, directed stimulus, pixel scoreboard.
module tb_text_render;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    text_render_if bus();

    text_render u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]  vram [2048];
    logic [7:0]  font [2048];
    logic [11:0] exp_q [$];
    int          checks;
    int          failures;
    logic        track;
    logic [10:0] max_addr;

    // Synchronous memories: data valid one cycle after the address
    always @(posedge clk) begin
        bus.vram_data <= vram[bus.vram_addr];
        bus.font_data <= font[bus.font_addr];
    end

    // Highest videoram address seen while tracking is on
    always @(posedge clk) begin
        if (!track) max_addr <= '0;
        else if (bus.vram_addr > max_addr) max_addr <= bus.vram_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted advance presents one pixel that must match the queue head
    always @(negedge clk) begin
        if (!reset && bus.advance && !bus.newline) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pixel_unexpected actual=%0h required=none", bus.pixel);
            end else begin
                check("pixel", 32'(bus.pixel), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_newline();
        bus.newline = 1'b1;
        step();
        bus.newline = 1'b0;
    endtask

    task automatic pulse_newframe();
        bus.newframe = 1'b1;
        step();
        bus.newframe = 1'b0;
    endtask

    task automatic run_part(input logic [7:0] g, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bus.advance = 1'b1;
            exp_q.push_back(g[7-i] ? 12'hFFF : 12'h000);
            step();
        end
        bus.advance = 1'b0;
    endtask

    task automatic run_glyph(input logic [7:0] g);
        run_part(g, 0, 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        track = 1'b0;
        bus.newframe = 1'b0;
        bus.newline = 1'b0;
        bus.advance = 1'b0;
        bus.cursor_addr = '0;
        bus.cursor_en = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            vram[i] = 8'h00;
            font[i] = 8'h00;
        end
        reset = 1'b1;
        idle(2);
        check("reset_pixel", 32'(bus.pixel), 32'h000);
        check("reset_vram_addr", 32'(bus.vram_addr), 32'h0);
        check("reset_font_addr", 32'(bus.font_addr), 32'h0);
        reset = 1'b0;
        step();

        // Basic glyph 'A' row 0
        vram[0] = 8'h41;
        font[{7'h41, 4'd0}] = 8'hA0;
        pulse_newframe();
        pulse_newline();
        idle(3);
        run_part(8'hA0, 0, 4);
        check("next_cell_addr", 32'(bus.vram_addr), 32'd1);
        run_part(8'hA0, 4, 8);

        // Continuous stream of 64 alternating cells
        for (int c = 0; c < 64; c++) vram[c] = c[0] ? 8'h11 : 8'h10;
        font[{7'h10, 4'd0}] = 8'hFF;
        font[{7'h11, 4'd0}] = 8'h00;
        pulse_newframe();
        pulse_newline();
        track = 1'b1;
        idle(3);
        for (int k = 0; k < 64; k++) run_glyph(k[0] ? 8'h00 : 8'hFF);
        idle(4);
        check("line_end_pixel", 32'(bus.pixel), 32'h000);
        check("line_end_max_addr", 32'(max_addr), 32'd63);
        check("line_end_vram_addr", 32'(bus.vram_addr), 32'd63);
        track = 1'b0;

        // Row/scan wrap and end of frame
        vram[64] = 8'h23;
        pulse_newframe();
        for (int n = 1; n <= 17; n++) begin
            pulse_newline();
            if (n == 17) check("row1_vram_addr", 32'(bus.vram_addr), 32'd64);
            step();
            if (n == 16) check("scan15_font_addr", 32'(bus.font_addr), 32'h10F);
            if (n == 17) check("row1_font_addr", 32'(bus.font_addr), 32'h230);
            idle(6);
        end
        for (int n = 18; n <= 480; n++) begin
            pulse_newline();
            idle(7);
        end
        check("last_line_vram_addr", 32'(bus.vram_addr), 32'd1857);
        pulse_newline();
        idle(7);
        check("row30_no_fetch", 32'(bus.vram_addr), 32'd1857);
        run_part(8'h00, 0, 8);
        check("row30_pixel", 32'(bus.pixel), 32'h000);

        // Inverse video cell
        vram[0] = 8'hC1;
        font[{7'h41, 4'd0}] = 8'h80;
        pulse_newframe();
        pulse_newline();
        idle(3);
        run_glyph(8'h7F);

        // Cursor with blink high on scanline 14
        bus.cursor_en = 1'b1;
        bus.cursor_addr = 11'd0;
        vram[0] = 8'h05;
        font[{7'h05, 4'd14}] = 8'hF0;
        repeat (13) pulse_newframe();
        repeat (15) begin
            pulse_newline();
            idle(3);
        end
        run_glyph(8'h0F);

        // Cursor with blink low (counter wrapped to 0)
        repeat (15) pulse_newframe();
        repeat (15) begin
            pulse_newline();
            idle(3);
        end
        run_glyph(8'hF0);
        bus.cursor_en = 1'b0;

        // Newline colliding with advance mid-character
        vram[0] = 8'h06;
        font[{7'h06, 4'd0}] = 8'hC3;
        font[{7'h06, 4'd1}] = 8'h5A;
        font[{7'h06, 4'd2}] = 8'hFF;
        pulse_newframe();
        pulse_newline();
        idle(3);
        run_part(8'hC3, 0, 3);
        bus.newline = 1'b1;
        bus.advance = 1'b1;
        step();
        bus.newline = 1'b0;
        bus.advance = 1'b0;
        check("collide_vram_addr", 32'(bus.vram_addr), 32'd0);
        step();
        check("collide_font_addr", 32'(bus.font_addr), 32'h061);
        idle(2);
        run_glyph(8'h5A);

        // Newframe together with newline starts at row 0 scan 0
        bus.newframe = 1'b1;
        bus.newline = 1'b1;
        step();
        bus.newframe = 1'b0;
        bus.newline = 1'b0;
        check("frame_line_vram_addr", 32'(bus.vram_addr), 32'd0);
        step();
        check("frame_line_font_addr", 32'(bus.font_addr), 32'h060);
        idle(2);
        run_glyph(8'hC3);
        pulse_newline();
        step();
        check("after_frame_line_font_addr", 32'(bus.font_addr), 32'h061);
        idle(2);
        run_glyph(8'h5A);

        // Reset mid-line with the shifter full
        pulse_newline();
        idle(3);
        run_part(8'hFF, 0, 3);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_pixel", 32'(bus.pixel), 32'h000);
        check("midreset_vram_addr", 32'(bus.vram_addr), 32'h0);
        check("midreset_font_addr", 32'(bus.font_addr), 32'h0);
        idle(2);
        reset = 1'b0;
        idle(3);
        run_part(8'h00, 0, 4);
        check("post_reset_vram_addr", 32'(bus.vram_addr), 32'h0);
        check("post_reset_font_addr", 32'(bus.font_addr), 32'h0);
        pulse_newline();
        idle(3);
        run_glyph(8'hC3);

        idle(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_render.md
Name: text_render

Overview:
- Text-mode character generator for the 640x480 VGA path.
- Sits between the videoram read port and the vga timing block.
- Walks a 64x30 character grid held in videoram (one byte per cell, address = row*64 + col) and expands each cell through an 8x16 font ROM.
- Produces a 12-bit RGB pixel per advance strobe; replaces the raw pixel fetcher when the text console is enabled.

Parameters:
- FG_COLOR, 12'hFFF, RGB444 colour for a set font bit.
- BG_COLOR, 12'h000, RGB444 colour for a clear font bit, for columns >= 64 and for rows >= 30.
- COLS, 64, characters per line; fixed at 64 so that address = {row, col[5:0]}.
- ROWS, 30, character rows per frame.

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- reset  in  1  asynchronous, active-high.
- newframe  in  1  one-cycle pulse before the first line of a frame.
- newline  in  1  one-cycle pulse at least 3 cycles before the first advance of each active line.
- advance  in  1  consume current pixel, present next; at most one per cycle.
- vram_addr  out  11  character cell address.
- vram_data  in  8  cell byte; valid 1 cycle after vram_addr.
- font_addr  out  11  {char[6:0], scan[3:0]}.
- font_data  in  8  glyph row, bit 7 = leftmost pixel; valid 1 cycle after font_addr.
- cursor_addr  in  11  cell address of the cursor.
- cursor_en  in  1  enables the cursor overlay.
- pixel  out  12  current RGB444 pixel.

Behaviour:
- Reset (async):
  - row=0, scan=0, col=0, first_line=1, blink counter=0.
  - Shifter and prefetch buffer = 0, buffer-valid=0, FSM=IDLE.
  - vram_addr=0, font_addr=0, pixel=BG_COLOR.
- newframe: row=0, scan=0, first_line=1, blink counter += 1 (5 bits; wraps from 31 to 0).
- newline:
  - If first_line, clear first_line and keep row/scan.
  - Otherwise scan += 1; when scan wraps 15->0, row += 1 (row saturates at ROWS).
  - Always: col=0, buffer-valid=0, shifter marked empty, FSM -> FETCH_CHAR.
  - If newline and advance arrive in the same cycle, newline wins and the advance is dropped.
  - If newframe and newline arrive in the same cycle, newframe is applied first and newline is then treated as the first line.
- FSM:
  - IDLE -> FETCH_CHAR on a fetch request.
  - FETCH_CHAR: drive vram_addr={row[4:0], col[5:0]}; next FONT.
  - FONT: capture vram_data; drive font_addr={vram_data[6:0], scan}; next LOAD.
  - LOAD: glyph = font_data, inverted if vram_data bit 7 = 1 (inverse video).
  - Cursor: if cursor_en and cell address == cursor_addr and blink[4]=1 and scan is 14 or 15, the glyph is inverted; this inversion is applied after the inverse-video inversion.
  - LOAD writes the glyph into the prefetch buffer, sets buffer-valid and increments col; then IDLE.
- Shifter:
  - When the shifter is empty and buffer-valid=1, the buffer moves into the shifter (pixel count = 8) and buffer-valid clears; a new fetch request is raised in the same cycle.
  - Each advance shifts left by one and decrements the count.
  - The 8th advance empties the shifter; the buffer is reloaded that same cycle, so there is no bubble. Fetch latency is 3 cycles, which is less than 8 pixels.
- Pixel:
  - pixel = FG_COLOR if shifter bit 7 = 1, else BG_COLOR. It is a registered state decode with no advance-to-pixel latency.
  - Forced to BG_COLOR when the shifter is empty, col > COLS (line finished), or row >= ROWS.
  - Fetches are suppressed when col == COLS or row >= ROWS.
- If advance occurs while the shifter is empty (protocol violation), pixel = BG_COLOR and no state changes.
- Reset asserted mid-line: all state returns to reset values immediately; the first line after release requires a newframe or newline before output resumes.

Test Plan:
- Reset: assert reset mid-line with the shifter full -> pixel=12'h000, vram_addr=0, font_addr=0 within the same cycle; they hold until a newline after release.
- Basic glyph:
  - Stimulus: vram[0]=8'h41, font[{7'h41,4'd0}]=8'b10100000; newframe, newline, 3 idle cycles, then 8 advances.
  - Required: pixel sequence F,0,F,0,0,0,0,0 (as FFF/000), and vram_addr=1 is issued during the first character.
- Continuous stream: 64 cells with alternating 8'hFF/8'h00 glyphs, advance every cycle for 512 cycles -> blocks of 8 FFF / 8 000 with no gap; after the 512th advance pixel=000 and no vram_addr beyond 63 is issued.
- Row/scan wrap: 17 newlines after newframe -> the 17th line drives font_addr scan=0 and vram_addr=64; after 480 newlines row=30 and pixel stays 000.
- Inverse and cursor:
  - Cell 8'hC1 with glyph 8'h80 -> 0,F,F,F,F,F,F,F.
  - cursor_addr=0, cursor_en=1, blink[4]=1 (16 newframes), scan 14 -> glyph inverted; with blink[4]=0 -> not inverted.
- Collision: newline and advance in the same cycle while mid-character -> col=0, the advance is ignored and the next line's first pixel is correct; newframe together with newline -> row=0, scan=0 are used.
